// File: rtl/seq_det_param_if.sv
// Bus bundle for the serial sequence detector: stream, configuration and result signals.
interface seq_det_param_if #(
    parameter int unsigned LEN   = 3,
    parameter int unsigned CNT_W = 8
);
    logic             inp;
    logic             inp_vld;
    logic             cfg_load;
    logic [LEN-1:0]   cfg_pat;
    logic             cnt_clr;
    logic             det;
    logic [CNT_W-1:0] match_cnt;
    logic [LEN-1:0]   pat;

    // Driver side: the stream source / configuration master.
    modport master (
        output inp, inp_vld, cfg_load, cfg_pat, cnt_clr,
        input  det, match_cnt, pat
    );

    // Detector side.
    modport slave (
        input  inp, inp_vld, cfg_load, cfg_pat, cnt_clr,
        output det, match_cnt, pat
    );
endinterface

// File: rtl/seq_det_param.sv
// Serial sequence detector: matches a 1-bit stream against a run-time programmable
// LEN-bit pattern (MSB received first), with Mealy/Moore output timing, overlapping
// or non-overlapping detection and a saturating match counter.
module seq_det_param #(
    parameter int unsigned    LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = LEN'(3'b001),
    parameter bit             OVERLAP = 1'b1,
    parameter bit             MOORE   = 1'b0,
    parameter int unsigned    CNT_W   = 8
) (
    input logic            clk,
    input logic            rst,
    seq_det_param_if.slave bus
);
    localparam int unsigned      FILL_W    = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [LEN-1:0]    r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [LEN-1:0]    r_pat;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_beat;
    logic [LEN-1:0]    w_cand;
    logic              w_hit;

    // A configuration load swallows any beat presented in the same cycle.
    assign w_beat = bus.inp_vld & ~bus.cfg_load;
    assign w_cand = {r_hist[LEN-2:0], bus.inp};
    // Requiring LEN-1 held bits stops stale zero history from matching early.
    assign w_hit  = w_beat && (r_fill >= FILL_ARM) && (w_cand == r_pat);

    // Shift history and valid-bit fill level; cleared on load or a non-overlapping match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (bus.cfg_load) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (w_beat) begin
            if (w_hit && !OVERLAP) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_cand;
                r_fill <= (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
            end
        end
    end

    // Programmable pattern register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat <= PATTERN;
        end else if (bus.cfg_load) begin
            r_pat <= bus.cfg_pat;
        end
    end

    // Saturating match counter; a clear coinciding with a hit counts that hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_hit) begin
            if (bus.cnt_clr) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (bus.cnt_clr) begin
            r_cnt <= '0;
        end
    end

    generate
        if (MOORE) begin : g_moore
            logic r_det_q;

            // Registered detect pulse, one cycle after the final pattern bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_det_q <= 1'b0;
                end else begin
                    r_det_q <= w_hit;
                end
            end

            assign bus.det = r_det_q;
        end else begin : g_mealy
            // Combinational detect in the cycle of the final pattern bit.
            assign bus.det = w_hit & ~rst;
        end
    endgenerate

    assign bus.match_cnt = r_cnt;
    assign bus.pat       = r_pat;

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: four configurations share one stimulus stream; a
// bit-queue reference model predicts each cycle's outputs into a scoreboard queue
// that a negedge monitor drains and compares.
module tb_seq_det_param;
    localparam int NDUT = 4;

    typedef struct {
        int k;
        int cyc;
        bit det;
        int cnt;
        int pat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_inp, s_vld, s_load, s_clr;
    logic [4:0] s_cfg;

    always #5 clk = ~clk;

    // DUT configurations
    int m_len   [NDUT] = '{3, 3, 5, 3};
    bit m_ov    [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit m_moore [NDUT] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int m_cntw  [NDUT] = '{8, 2, 4, 8};
    int m_prst  [NDUT] = '{1, 5, 22, 5};

    seq_det_param_if #(.LEN(3), .CNT_W(8)) if0 ();
    seq_det_param_if #(.LEN(3), .CNT_W(2)) if1 ();
    seq_det_param_if #(.LEN(5), .CNT_W(4)) if2 ();
    seq_det_param_if #(.LEN(3), .CNT_W(8)) if3 ();

    assign if0.inp = s_inp;  assign if0.inp_vld = s_vld;  assign if0.cfg_load = s_load;
    assign if0.cnt_clr = s_clr;  assign if0.cfg_pat = s_cfg[2:0];
    assign if1.inp = s_inp;  assign if1.inp_vld = s_vld;  assign if1.cfg_load = s_load;
    assign if1.cnt_clr = s_clr;  assign if1.cfg_pat = s_cfg[2:0];
    assign if2.inp = s_inp;  assign if2.inp_vld = s_vld;  assign if2.cfg_load = s_load;
    assign if2.cnt_clr = s_clr;  assign if2.cfg_pat = s_cfg;
    assign if3.inp = s_inp;  assign if3.inp_vld = s_vld;  assign if3.cfg_load = s_load;
    assign if3.cnt_clr = s_clr;  assign if3.cfg_pat = s_cfg[2:0];

    seq_det_param #(.LEN(3), .PATTERN(3'b001), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8))
        u_d0 (.clk(clk), .rst(rst), .bus(if0));
    seq_det_param #(.LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .MOORE(1'b1), .CNT_W(2))
        u_d1 (.clk(clk), .rst(rst), .bus(if1));
    seq_det_param #(.LEN(5), .PATTERN(5'b10110), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(4))
        u_d2 (.clk(clk), .rst(rst), .bus(if2));
    seq_det_param #(.LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8))
        u_d3 (.clk(clk), .rst(rst), .bus(if3));

    // Reference model state: valid bits received since the last clear, oldest first
    bit   hq   [NDUT][$];
    int   mpat [NDUT];
    int   mcnt [NDUT];
    bit   mdq  [NDUT];
    exp_t exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;

    function automatic int win_val(int k);
        int v = 0;
        for (int j = 0; j < hq[k].size(); j++) v = (v << 1) | int'(hq[k][j]);
        return v;
    endfunction

    // Drive one cycle, predict every DUT's outputs for it, advance the model.
    task automatic cyc(input bit i, input bit v, input bit l, input bit c, input bit r,
                       input logic [4:0] cfg);
        exp_t e;
        bit   hit;
        int   mask, cmax;
        s_inp = i; s_vld = v; s_load = l; s_clr = c; s_cfg = cfg; rst = r;
        for (int k = 0; k < NDUT; k++) begin
            e.k = k; e.cyc = cyc_no;
            if (r) begin
                hq[k].delete();
                mpat[k] = m_prst[k]; mcnt[k] = 0; mdq[k] = 1'b0;
                e.det = 1'b0; e.cnt = 0; e.pat = m_prst[k];
            end else begin
                hit  = 1'b0;
                mask = (1 << m_len[k]) - 1;
                cmax = (1 << m_cntw[k]) - 1;
                if (l) begin
                    hq[k].delete();
                end else if (v) begin
                    hq[k].push_back(i);
                    if (hq[k].size() > m_len[k]) void'(hq[k].pop_front());
                    if (hq[k].size() == m_len[k] && win_val(k) == mpat[k]) hit = 1'b1;
                    if (hit && !m_ov[k]) hq[k].delete();
                end
                e.det = m_moore[k] ? mdq[k] : hit;
                e.cnt = mcnt[k];
                e.pat = mpat[k];
                if (hit) mcnt[k] = c ? 1 : ((mcnt[k] < cmax) ? mcnt[k] + 1 : cmax);
                else if (c) mcnt[k] = 0;
                mdq[k] = hit;
                if (l) mpat[k] = int'(cfg) & mask;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic beat(input bit i);   cyc(i, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0); endtask
    task automatic idle(input bit i);   cyc(i, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); endtask
    task automatic do_rst();            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0); endtask

    // Monitor: compare every DUT's outputs with the scoreboard away from the clock edge.
    always @(negedge clk) begin
        exp_t e;
        bit   ad;
        int   ac, ap;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.k)
                0: begin ad = if0.det; ac = int'(if0.match_cnt); ap = int'(if0.pat); end
                1: begin ad = if1.det; ac = int'(if1.match_cnt); ap = int'(if1.pat); end
                2: begin ad = if2.det; ac = int'(if2.match_cnt); ap = int'(if2.pat); end
                default: begin ad = if3.det; ac = int'(if3.match_cnt); ap = int'(if3.pat); end
            endcase
            n_tests++;
            if (ad !== e.det || ac != e.cnt || ap != e.pat) begin
                n_fail++;
                $display("FAIL dut%0d cycle%0d: det got %0d want %0d, match_cnt got %0d want %0d, pat got %0h want %0h",
                         e.k, e.cyc, ad, e.det, ac, e.cnt, ap, e.pat);
            end
        end
    end

    initial begin
        rst = 1'b1; s_inp = 1'b0; s_vld = 1'b0; s_load = 1'b0; s_clr = 1'b0; s_cfg = '0;
        @(posedge clk);
        #1;
        // Basic detection
        do_rst(); beat(0); beat(0); beat(1); idle(0); idle(0);
        // Stale-zero history
        do_rst(); beat(0); beat(0); beat(0); beat(1); idle(1);
        // Overlap vs non-overlap on 101
        do_rst(); beat(1); beat(0); beat(1); beat(0); beat(1); idle(0); idle(0);
        // Valid gaps with toggling inp
        do_rst(); beat(0); idle(1); idle(0); beat(0); idle(1); beat(1); idle(0);
        // Load with a discarded beat in the same cycle
        do_rst(); beat(0); beat(0); cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00110);
        beat(1); beat(1); beat(0); idle(0);
        // Counter saturation on CNT_W=2 and on repeated matches
        do_rst();
        for (int n = 0; n < 5; n++) begin beat(1); beat(0); beat(1); end
        for (int n = 0; n < 5; n++) begin beat(0); beat(0); beat(1); end
        idle(0);
        // Clear together with a hit, then clear alone
        beat(0); beat(0); cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        beat(1); beat(0); cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0); idle(0);
        // Reset mid-pattern, then normal detection
        beat(0); beat(0); do_rst(); beat(0); beat(0); beat(1); idle(0);
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int rr;
            rr = $urandom_range(0, 199);
            if (rr < 2) do_rst();
            else if (rr < 6)
                cyc(1'($urandom), 1'($urandom), 1'b1, 1'($urandom_range(0, 29) == 0), 1'b0,
                    5'($urandom));
            else
                cyc(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0,
                    1'($urandom_range(0, 29) == 0), 1'b0, s_cfg);
        end
        idle(0);
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
